sha256_chunk_engine: RTL and testbench

SHA-256 compression responder: the hashing end of the chunk handshake used by the 1024-bit PBKDF2 wrapper (new_hash / in_valid / in_ready / out_valid / out_ready).
- Accepts one 512-bit pre-padded chunk per transaction.
- Either restarts from the IV or chains from the previous digest.
- Runs 64 rounds and holds the 256-bit digest until it is consumed.
- Sits directly under the wrapper FSM; one instance per hash lane.

---
 rtl/sha256_chunk_engine.sv | 215 +++++++++++++++++++++
 tb/tb_sha256_chunk_engine.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_chunk_engine.sv
// SHA-256 compression engine: one pre-padded 512-bit chunk per handshake, IV restart or chaining.
// Optional SHA256_ROUND_UNROLL2_EN computes two rounds per clock (same digests, shorter latency).
module sha256_chunk_engine #(
    parameter logic [255:0] IV_INIT = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         new_hash,
    input  logic         in_valid,
    input  logic [511:0] in,
    output logic         in_ready,
    output logic [255:0] out,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_FINAL = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

`ifdef SHA256_ROUND_UNROLL2_EN
    localparam logic [5:0] CNT_STEP = 6'd2;
    localparam logic [5:0] CNT_LAST = 6'd62;
`else
    localparam logic [5:0] CNT_STEP = 6'd1;
    localparam logic [5:0] CNT_LAST = 6'd63;
`endif

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // W[t+16] from the window words W[t], W[t+1], W[t+9], W[t+14].
    function automatic logic [31:0] msg_expand(input logic [31:0] w0, input logic [31:0] w1,
                                               input logic [31:0] w9, input logic [31:0] w14);
        return small_sigma1(w14) + w9 + small_sigma0(w1) + w0;
    endfunction

    // Working state packed as {a,b,c,d,e,f,g,h}, a in the MSBs.
    function automatic logic [255:0] sha_round(input logic [255:0] st, input logic [31:0] k,
                                               input logic [31:0] w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = st;
        t1 = h + big_sigma1(e) + ((e & f) ^ (~e & g)) + k + w;
        t2 = big_sigma0(a) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        r = 256'd0;
        for (int i = 0; i < 8; i++) begin
            r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
        end
        return r;
    endfunction

    function automatic logic [31:0] k_rom(input logic [5:0] idx);
        logic [31:0] k;
        case (idx)
            6'd0:  k = 32'h428a2f98;  6'd1:  k = 32'h71374491;  6'd2:  k = 32'hb5c0fbcf;  6'd3:  k = 32'he9b5dba5;
            6'd4:  k = 32'h3956c25b;  6'd5:  k = 32'h59f111f1;  6'd6:  k = 32'h923f82a4;  6'd7:  k = 32'hab1c5ed5;
            6'd8:  k = 32'hd807aa98;  6'd9:  k = 32'h12835b01;  6'd10: k = 32'h243185be;  6'd11: k = 32'h550c7dc3;
            6'd12: k = 32'h72be5d74;  6'd13: k = 32'h80deb1fe;  6'd14: k = 32'h9bdc06a7;  6'd15: k = 32'hc19bf174;
            6'd16: k = 32'he49b69c1;  6'd17: k = 32'hefbe4786;  6'd18: k = 32'h0fc19dc6;  6'd19: k = 32'h240ca1cc;
            6'd20: k = 32'h2de92c6f;  6'd21: k = 32'h4a7484aa;  6'd22: k = 32'h5cb0a9dc;  6'd23: k = 32'h76f988da;
            6'd24: k = 32'h983e5152;  6'd25: k = 32'ha831c66d;  6'd26: k = 32'hb00327c8;  6'd27: k = 32'hbf597fc7;
            6'd28: k = 32'hc6e00bf3;  6'd29: k = 32'hd5a79147;  6'd30: k = 32'h06ca6351;  6'd31: k = 32'h14292967;
            6'd32: k = 32'h27b70a85;  6'd33: k = 32'h2e1b2138;  6'd34: k = 32'h4d2c6dfc;  6'd35: k = 32'h53380d13;
            6'd36: k = 32'h650a7354;  6'd37: k = 32'h766a0abb;  6'd38: k = 32'h81c2c92e;  6'd39: k = 32'h92722c85;
            6'd40: k = 32'ha2bfe8a1;  6'd41: k = 32'ha81a664b;  6'd42: k = 32'hc24b8b70;  6'd43: k = 32'hc76c51a3;
            6'd44: k = 32'hd192e819;  6'd45: k = 32'hd6990624;  6'd46: k = 32'hf40e3585;  6'd47: k = 32'h106aa070;
            6'd48: k = 32'h19a4c116;  6'd49: k = 32'h1e376c08;  6'd50: k = 32'h2748774c;  6'd51: k = 32'h34b0bcb5;
            6'd52: k = 32'h391c0cb3;  6'd53: k = 32'h4ed8aa4a;  6'd54: k = 32'h5b9cca4f;  6'd55: k = 32'h682e6ff3;
            6'd56: k = 32'h748f82ee;  6'd57: k = 32'h78a5636f;  6'd58: k = 32'h84c87814;  6'd59: k = 32'h8cc70208;
            6'd60: k = 32'h90befffa;  6'd61: k = 32'ha4506ceb;  6'd62: k = 32'hbef9a3f7;  6'd63: k = 32'hc67178f2;
            default: k = 32'h00000000;
        endcase
        return k;
    endfunction

    logic [1:0]   state_r;
    logic [5:0]   cnt_r;
    logic [255:0] hash_r;
    logic [255:0] work_r;
    logic [31:0]  w_r [16];
    logic         in_ready_r;
    logic         out_valid_r;
    logic [255:0] work_next_s;
    logic [31:0]  w_next_s [16];
    logic         accept_s;
`ifdef SHA256_ROUND_UNROLL2_EN
    logic [255:0] work_mid_s;
`endif

    assign accept_s  = in_valid & in_ready_r;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out       = hash_r;

    // Next working state and sliding message window for the current ROUND cycle.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_next_s[i] = w_r[i];
        end
`ifdef SHA256_ROUND_UNROLL2_EN
        work_mid_s  = sha_round(work_r, k_rom(cnt_r), w_r[0]);
        work_next_s = sha_round(work_mid_s, k_rom(cnt_r + 6'd1), w_r[1]);
        for (int i = 0; i < 14; i++) begin
            w_next_s[i] = w_r[i + 2];
        end
        w_next_s[14] = msg_expand(w_r[0], w_r[1], w_r[9], w_r[14]);
        w_next_s[15] = msg_expand(w_r[1], w_r[2], w_r[10], w_r[15]);
`else
        work_next_s = sha_round(work_r, k_rom(cnt_r), w_r[0]);
        for (int i = 0; i < 15; i++) begin
            w_next_s[i] = w_r[i + 1];
        end
        w_next_s[15] = msg_expand(w_r[0], w_r[1], w_r[9], w_r[14]);
`endif
    end

    // Message window: load on accept, slide during rounds.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < 16; i++) begin
                w_r[i] <= 32'h00000000;
            end
        end else if (accept_s) begin
            for (int i = 0; i < 16; i++) begin
                w_r[i] <= in[511 - 32*i -: 32];
            end
        end else if (state_r == ST_ROUND) begin
            w_r <= w_next_s;
        end else begin
            w_r <= w_r;
        end
    end

    // Control FSM, hash/working registers and registered handshake outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 6'd0;
            hash_r      <= IV_INIT;
            work_r      <= 256'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (new_hash) begin
                            hash_r <= IV_INIT;
                            work_r <= IV_INIT;
                        end else begin
                            work_r <= hash_r;
                        end
                        cnt_r      <= 6'd0;
                        in_ready_r <= 1'b0;
                        state_r    <= ST_ROUND;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ROUND: begin
                    work_r <= work_next_s;
                    cnt_r  <= cnt_r + CNT_STEP;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_FINAL;
                    end else begin
                        state_r <= ST_ROUND;
                    end
                end
                ST_FINAL: begin
                    hash_r      <= add_words(hash_r, work_r);
                    out_valid_r <= 1'b1;
                    state_r     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_chunk_engine.sv
// Directed testbench for sha256_chunk_engine: known-answer digests, latency, chaining,
// backpressure, mid-round reset and input-hold behaviour.
module tb_sha256_chunk_engine;

    localparam logic [255:0] IV      = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] ABC_DIG = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] EMP_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] TWO_DIG = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
`ifdef SHA256_ROUND_UNROLL2_EN
    localparam int EXP_LAT = 33;
`else
    localparam int EXP_LAT = 65;
`endif

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         new_hash = 1'b0;
    logic         in_valid = 1'b0;
    logic [511:0] in_data = 512'd0;
    logic         in_ready;
    logic [255:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;

    logic [511:0] abc_blk;
    logic [511:0] emp_blk;
    logic [511:0] two_blk1;
    logic [511:0] two_blk2;

    int vectors = 0;
    int miscompares = 0;

    sha256_chunk_engine dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .new_hash  (new_hash),
        .in_valid  (in_valid),
        .in        (in_data),
        .in_ready  (in_ready),
        .out       (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Issue one chunk from IDLE and count edges until out_valid (capped at 200).
    task automatic run_chunk(input logic [511:0] chunk, input logic nh, input bit scramble,
                             output int lat, output bit rdy_bad, output bit excl_bad);
        in_data  = chunk;
        new_hash = nh;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        rdy_bad = 1'b0;
        excl_bad = 1'b0;
        while (lat < 200) begin
            tick();
            lat++;
            if (in_ready && out_valid) excl_bad = 1'b1;
            if (out_valid) break;
            if (in_ready) rdy_bad = 1'b1;
            if (scramble && lat == 3) begin
                for (int i = 0; i < 16; i++) in_data[32*i +: 32] = $urandom();
                new_hash = ~nh;
            end
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        vectors++;
        if (out_data !== IV) begin miscompares++; $display("FAIL reset_out: got %h expected %h", out_data, IV); end
    endtask

    task automatic test_chain_from_reset();
        int lat; bit rb; bit eb;
        run_chunk(abc_blk, 1'b0, 1'b0, lat, rb, eb);
        vectors++;
        if (out_data !== ABC_DIG) begin miscompares++; $display("FAIL chain_from_reset_digest: got %h expected %h", out_data, ABC_DIG); end
        consume();
    endtask

    task automatic test_abc();
        int lat; bit rb; bit eb;
        run_chunk(abc_blk, 1'b1, 1'b0, lat, rb, eb);
        vectors++;
        if (lat !== EXP_LAT) begin miscompares++; $display("FAIL abc_latency: got %0d expected %0d", lat, EXP_LAT); end
        vectors++;
        if (out_data !== ABC_DIG) begin miscompares++; $display("FAIL abc_digest: got %h expected %h", out_data, ABC_DIG); end
        vectors++;
        if (rb !== 1'b0) begin miscompares++; $display("FAIL abc_in_ready_busy: got %b expected 0", rb); end
        vectors++;
        if (eb !== 1'b0) begin miscompares++; $display("FAIL abc_handshake_exclusive: got %b expected 0", eb); end
        consume();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++; $display("FAIL abc_consume: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_empty();
        int lat; bit rb; bit eb;
        run_chunk(emp_blk, 1'b1, 1'b0, lat, rb, eb);
        vectors++;
        if (lat !== EXP_LAT) begin miscompares++; $display("FAIL empty_latency: got %0d expected %0d", lat, EXP_LAT); end
        vectors++;
        if (out_data !== EMP_DIG) begin miscompares++; $display("FAIL empty_digest: got %h expected %h", out_data, EMP_DIG); end
        consume();
    endtask

    task automatic test_two_block();
        int lat; bit rb; bit eb;
        run_chunk(two_blk1, 1'b1, 1'b0, lat, rb, eb);
        consume();
        run_chunk(two_blk2, 1'b0, 1'b0, lat, rb, eb);
        vectors++;
        if (out_data !== TWO_DIG) begin miscompares++; $display("FAIL two_block_digest: got %h expected %h", out_data, TWO_DIG); end
        consume();
        run_chunk(abc_blk, 1'b1, 1'b0, lat, rb, eb);
        vectors++;
        if (out_data !== ABC_DIG) begin miscompares++; $display("FAIL abc_after_chain: got %h expected %h", out_data, ABC_DIG); end
    endtask

    // Entered with the engine in DONE holding the "abc" digest.
    task automatic test_backpressure();
        bit out_bad = 1'b0;
        bit valid_bad = 1'b0;
        bit ready_bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            in_valid = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < 16; i++) in_data[32*i +: 32] = $urandom();
            new_hash = ($urandom_range(0, 1) == 1);
            tick();
            if (out_data !== ABC_DIG) out_bad = 1'b1;
            if (out_valid !== 1'b1) valid_bad = 1'b1;
            if (in_ready !== 1'b0) ready_bad = 1'b1;
        end
        in_valid = 1'b0;
        vectors++;
        if (out_bad) begin miscompares++; $display("FAIL bp_out_stable: got %h expected %h", out_data, ABC_DIG); end
        vectors++;
        if (valid_bad) begin miscompares++; $display("FAIL bp_out_valid_held: got %b expected 1", valid_bad); end
        vectors++;
        if (ready_bad) begin miscompares++; $display("FAIL bp_in_ready_low: got %b expected 0", ready_bad); end
        consume();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++; $display("FAIL bp_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        vectors++;
        if (out_data !== ABC_DIG) begin miscompares++; $display("FAIL bp_no_accept: got %h expected %h", out_data, ABC_DIG); end
    endtask

    // Entered in IDLE with H = "abc" digest; a chained chunk is aborted by reset.
    task automatic test_reset_mid_round();
        int lat; bit rb; bit eb;
        bit stray = 1'b0;
        in_data  = abc_blk;
        new_hash = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (30) tick();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midreset_in_ready: got %b expected 1", in_ready); end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_out_valid: got %b expected 0", out_valid); end
        vectors++;
        if (out_data !== IV) begin miscompares++; $display("FAIL midreset_out: got %h expected %h", out_data, IV); end
        for (int c = 0; c < 70; c++) begin
            tick();
            if (out_valid !== 1'b0) stray = 1'b1;
        end
        vectors++;
        if (stray) begin miscompares++; $display("FAIL midreset_no_output: got %b expected 0", stray); end
        run_chunk(abc_blk, 1'b1, 1'b0, lat, rb, eb);
        vectors++;
        if (out_data !== ABC_DIG || lat !== EXP_LAT) begin
            miscompares++; $display("FAIL midreset_fresh_abc: got %h lat %0d expected %h lat %0d", out_data, lat, ABC_DIG, EXP_LAT);
        end
        consume();
    endtask

    task automatic test_input_hold();
        int lat; bit rb; bit eb;
        run_chunk(abc_blk, 1'b1, 1'b1, lat, rb, eb);
        vectors++;
        if (out_data !== ABC_DIG) begin miscompares++; $display("FAIL input_hold_digest: got %h expected %h", out_data, ABC_DIG); end
        consume();
    endtask

    initial begin
        abc_blk  = {32'h61626380, 448'd0, 32'h00000018};
        emp_blk  = {32'h80000000, 480'd0};
        two_blk1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        two_blk2 = {480'd0, 32'h000001c0};
        test_reset();
        test_chain_from_reset();
        test_abc();
        test_empty();
        test_two_block();
        test_backpressure();
        test_reset_mid_round();
        test_input_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
